// File: rtl/scpu_pkg.sv
// Shared definitions for the simple CPU: one-hot ALU opcodes (identical to the
// control unit's encoding), flag bit positions inside the {V,N,C,Z} vector and
// the ALU sequencer state encoding.
package scpu_pkg;

  localparam logic [7:0] ALU_ADD = 8'h01;
  localparam logic [7:0] ALU_SUB = 8'h02;
  localparam logic [7:0] ALU_MUL = 8'h04;
  localparam logic [7:0] ALU_DIV = 8'h08;
  localparam logic [7:0] ALU_AND = 8'h10;
  localparam logic [7:0] ALU_OR  = 8'h20;
  localparam logic [7:0] ALU_XOR = 8'h40;
  localparam logic [7:0] ALU_CMP = 8'h80;

  localparam int FLAG_Z = 0;
  localparam int FLAG_C = 1;
  localparam int FLAG_N = 2;
  localparam int FLAG_V = 3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MUL_RUN = 2'd1,
    ST_DIV_RUN = 2'd2
  } alu_state_t;

endpackage

// File: rtl/alu_muldiv_seq.sv
// Iterative multiply / divide engine, one bit per clock for WIDTH clocks.
//   MUL: shift-add, {res_hi,res_lo} = a * b (unsigned).
//   DIV: restoring shift-subtract, res_lo = a / b, res_hi = a % b (b != 0).
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   start             load operands and begin (ignored if a run is active only
//                     by construction: the caller never starts while busy)
//   op_div            0 = multiply, 1 = divide; sampled with start
//   a_in, b_in        operands, sampled with start
//   done              high during the cycle whose edge performs the last step
//   res_lo, res_hi    accumulator halves; valid the cycle after done
module alu_muldiv_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             op_div,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             done,
  output logic [WIDTH-1:0] res_lo,
  output logic [WIDTH-1:0] res_hi
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [2*WIDTH-1:0] acc, acc_nxt;
  logic [WIDTH-1:0]   opb;
  logic [CW-1:0]      cnt;
  logic               run, div_q;
  logic [WIDTH:0]     add_t, sub_t;

  always_comb begin
    add_t   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, opb};
    // Partial remainder shifted left with the next dividend bit; it stays
    // below 2*b so WIDTH+1 bits are enough and bit WIDTH is the borrow.
    sub_t   = acc[2*WIDTH-1:WIDTH-1] - {1'b0, opb};
    acc_nxt = acc;
    if (div_q) begin
      if (!sub_t[WIDTH])
        acc_nxt = {sub_t[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      else
        acc_nxt = {acc[2*WIDTH-2:0], 1'b0};
    end else if (acc[0]) begin
      acc_nxt = {add_t, acc[WIDTH-1:1]};
    end else begin
      acc_nxt = {1'b0, acc[2*WIDTH-1:1]};
    end
  end

  assign done   = run && (cnt == LAST);
  assign res_lo = acc[WIDTH-1:0];
  assign res_hi = acc[2*WIDTH-1:WIDTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc   <= '0;
      opb   <= '0;
      cnt   <= '0;
      run   <= 1'b0;
      div_q <= 1'b0;
    end else if (start) begin
      acc   <= {{WIDTH{1'b0}}, a_in};
      opb   <= b_in;
      cnt   <= '0;
      run   <= 1'b1;
      div_q <= op_div;
    end else if (run) begin
      acc <= acc_nxt;
      cnt <= cnt + 1'b1;
      if (done) run <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_unit.sv
// Sequential ALU fed by the control unit. Single-cycle ops (ADD/SUB/AND/OR/
// XOR/CMP) respond one cycle after acceptance; MUL/DIV use the iterative
// engine (alu_muldiv_seq) and hold busy while it runs.
// Build option: define ALU_MULDIV_EN to build MUL/DIV. Without it MUL/DIV are
// reported as illegal, result_hi and busy are tied low.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   alu_en, alu_opr     request strobe and one-hot opcode (scpu_pkg::ALU_*)
//   a_in, b_in          operands from the register file read ports
//   result, result_hi   primary result / product high byte or remainder
//   result_we           one-cycle register-file write strobe
//   busy                MUL/DIV in progress
//   flags               {V,N,C,Z}, registered
//   illegal             one-cycle pulse for a non-one-hot (or unbuilt) opcode
module alu_unit #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             alu_en,
  input  logic [7:0]       alu_opr,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             result_we,
  output logic             busy,
  output logic [3:0]       flags,
  output logic             illegal
);
  import scpu_pkg::*;

  localparam int MSB = WIDTH - 1;

  alu_state_t       state, state_nxt;
  logic [7:0]       op_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic             pend_q, accept, md_start, fire;
  logic [WIDTH:0]   sum_t, diff_t;
  logic [WIDTH-1:0] val, res_nxt;
  logic [3:0]       flags_nxt;
  logic             c_bit, v_bit, wr, legal, we_nxt, ill_nxt;

  assign accept = alu_en && (state == ST_IDLE);

`ifdef ALU_MULDIV_EN
  logic             md_done, md_pend_q;
  logic [WIDTH-1:0] md_lo, md_hi, hi_nxt;

  // A zero divisor bypasses the engine and completes on the single-cycle path.
  assign md_start = accept && ((alu_opr == ALU_MUL) ||
                               ((alu_opr == ALU_DIV) && (b_in != '0)));
  assign fire     = pend_q || md_pend_q;

  alu_muldiv_seq #(.WIDTH(WIDTH)) u_muldiv (
    .clk    (clk),
    .rst    (rst),
    .start  (md_start),
    .op_div (alu_opr == ALU_DIV),
    .a_in   (a_in),
    .b_in   (b_in),
    .done   (md_done),
    .res_lo (md_lo),
    .res_hi (md_hi)
  );
`else
  assign md_start = 1'b0;
  assign fire     = pend_q;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
`ifdef ALU_MULDIV_EN
    case (state)
      ST_IDLE:    if (md_start) state_nxt = (alu_opr == ALU_MUL) ? ST_MUL_RUN : ST_DIV_RUN;
      ST_MUL_RUN,
      ST_DIV_RUN: if (md_done) state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
`else
    state_nxt = ST_IDLE;
`endif
  end

  // Request capture: single-cycle ops (and illegal codes) are evaluated from
  // these registers on the following edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q   <= '0;
      a_q    <= '0;
      b_q    <= '0;
      pend_q <= 1'b0;
    end else begin
      pend_q <= accept && !md_start;
      if (accept) begin
        op_q <= alu_opr;
        a_q  <= a_in;
        b_q  <= b_in;
      end
    end
  end

  always_comb begin
    sum_t  = {1'b0, a_q} + {1'b0, b_q};
    diff_t = {1'b0, a_q} - {1'b0, b_q};
    val    = '0;
    c_bit  = 1'b0;
    v_bit  = 1'b0;
    wr     = 1'b1;
    legal  = 1'b1;
`ifdef ALU_MULDIV_EN
    hi_nxt = result_hi;
`endif
    case (op_q)
      ALU_ADD: begin
        val   = sum_t[MSB:0];
        c_bit = sum_t[WIDTH];
        v_bit = (a_q[MSB] == b_q[MSB]) && (sum_t[MSB] != a_q[MSB]);
      end
      ALU_SUB, ALU_CMP: begin
        val   = diff_t[MSB:0];
        c_bit = diff_t[WIDTH];
        v_bit = (a_q[MSB] != b_q[MSB]) && (diff_t[MSB] != a_q[MSB]);
        wr    = (op_q != ALU_CMP);
      end
      ALU_AND: val = a_q & b_q;
      ALU_OR:  val = a_q | b_q;
      ALU_XOR: val = a_q ^ b_q;
`ifdef ALU_MULDIV_EN
      // Only a zero divisor takes this path.
      ALU_DIV: begin
        val    = '1;
        hi_nxt = a_q;
        c_bit  = 1'b1;
        v_bit  = 1'b1;
      end
`endif
      default: legal = 1'b0;
    endcase
`ifdef ALU_MULDIV_EN
    if (md_pend_q) begin
      val    = md_lo;
      hi_nxt = md_hi;
      wr     = 1'b1;
      legal  = 1'b1;
      v_bit  = 1'b0;
      c_bit  = (op_q == ALU_MUL) && (md_hi != '0);
    end
`endif
    res_nxt   = result;
    flags_nxt = flags;
    we_nxt    = 1'b0;
    ill_nxt   = 1'b0;
    if (fire) begin
      if (!legal) begin
        ill_nxt = 1'b1;
      end else begin
        flags_nxt[FLAG_Z] = (val == '0);
        flags_nxt[FLAG_N] = val[MSB];
        flags_nxt[FLAG_C] = c_bit;
        flags_nxt[FLAG_V] = v_bit;
        if (wr) begin
          res_nxt = val;
          we_nxt  = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result    <= '0;
      flags     <= '0;
      result_we <= 1'b0;
      illegal   <= 1'b0;
    end else begin
      result    <= res_nxt;
      flags     <= flags_nxt;
      result_we <= we_nxt;
      illegal   <= ill_nxt;
    end
  end

`ifdef ALU_MULDIV_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result_hi <= '0;
      busy      <= 1'b0;
      md_pend_q <= 1'b0;
    end else begin
      if (we_nxt) result_hi <= hi_nxt;
      busy      <= (state_nxt != ST_IDLE);
      md_pend_q <= md_done;
    end
  end
`else
  assign result_hi = '0;
  assign busy      = 1'b0;
`endif

endmodule

// File: tb/tb_alu_unit.sv
module tb_alu_unit;
  import scpu_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       alu_en = 1'b0;
  logic [7:0] alu_opr = '0;
  logic [7:0] a_in = '0;
  logic [7:0] b_in = '0;
  logic [7:0] result, result_hi;
  logic       result_we, busy, illegal;
  logic [3:0] flags;

  alu_unit #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .alu_en    (alu_en),
    .alu_opr   (alu_opr),
    .a_in      (a_in),
    .b_in      (b_in),
    .result    (result),
    .result_hi (result_hi),
    .result_we (result_we),
    .busy      (busy),
    .flags     (flags),
    .illegal   (illegal)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    string       name;
    int unsigned due;
    logic        we, ill, bsy, chk;
    logic [7:0]  res, hi;
    logic [3:0]  flg;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;

  // Expected held output values (what the DUT should currently present).
  logic [7:0] m_res = '0;
  logic [7:0] m_hi  = '0;
  logic [3:0] m_flg = '0;

  localparam int K_WR = 0, K_WRH = 1, K_CMP = 2, K_ILL = 3, K_MD = 4, K_MDR = 5;

  task automatic cmp(input string nm, input string fld, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s %s: got %h expected %h (cycle %0d)", nm, fld, got, exp, cyc);
    end
  endtask

  task automatic push(input string nm, input int unsigned due, input logic we, ill, bsy, chk);
    exp_t e;
    e.name = nm; e.due = due; e.we = we; e.ill = ill; e.bsy = bsy; e.chk = chk;
    e.res = m_res; e.hi = m_hi; e.flg = m_flg;
    sbq.push_back(e);
  endtask

  // Called on a negedge: the request is accepted on the next posedge, whose
  // cycle number is n. Returns on the following negedge with alu_en still set.
  task automatic issue(input string nm, input logic [7:0] opr, a, b, input int kind,
                       input logic [7:0] r, h, input logic [3:0] f);
    int unsigned n;
    n = cyc + 1;
    alu_en = 1'b1; alu_opr = opr; a_in = a; b_in = b;
    case (kind)
      K_WR:  begin m_res = r; m_flg = f; push(nm, n + 1, 1'b1, 1'b0, 1'b0, 1'b1); end
      K_WRH: begin m_res = r; m_hi = h; m_flg = f; push(nm, n + 1, 1'b1, 1'b0, 1'b0, 1'b1); end
      K_CMP: begin m_flg = f; push(nm, n + 1, 1'b0, 1'b0, 1'b0, 1'b1); end
      K_ILL: push(nm, n + 1, 1'b0, 1'b1, 1'b0, 1'b1);
      K_MD: begin
        for (int i = 0; i < 8; i++) push({nm, "_busy"}, n + i, 1'b0, 1'b0, 1'b1, 1'b0);
        push({nm, "_busy_fall"}, n + 8, 1'b0, 1'b0, 1'b0, 1'b0);
        m_res = r; m_hi = h; m_flg = f;
        push(nm, n + 9, 1'b1, 1'b0, 1'b0, 1'b1);
      end
      K_MDR: for (int i = 0; i < 4; i++) push({nm, "_busy"}, n + i, 1'b0, 1'b0, 1'b1, 1'b0);
      default: ;
    endcase
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    alu_en = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  // Monitor: checks every entry due this cycle; any write/illegal pulse in a
  // cycle with no expectation is an error.
  always @(negedge clk) begin
    bit   seen;
    exp_t e;
    seen = 1'b0;
    while (sbq.size() > 0 && sbq[0].due <= cyc) begin
      e = sbq.pop_front();
      if (e.due < cyc) begin
        checks++; errors++;
        $display("FAIL %s: response slot missed (due %0d, now %0d)", e.name, e.due, cyc);
      end else begin
        seen = 1'b1;
        cmp(e.name, "result_we", {7'b0, result_we}, {7'b0, e.we});
        cmp(e.name, "illegal",   {7'b0, illegal},   {7'b0, e.ill});
        cmp(e.name, "busy",      {7'b0, busy},      {7'b0, e.bsy});
        if (e.chk) begin
          cmp(e.name, "result",    result,          e.res);
          cmp(e.name, "result_hi", result_hi,       e.hi);
          cmp(e.name, "flags",     {4'b0, flags},   {4'b0, e.flg});
        end
      end
    end
    if (!seen && (result_we || illegal)) begin
      checks++; errors++;
      $display("FAIL unexpected_pulse: result_we=%b illegal=%b required 0 0 (cycle %0d)",
               result_we, illegal, cyc);
    end
  end

  initial begin
    repeat (2) @(posedge clk);
    #2 push("reset_state", cyc, 1'b0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    #1 rst = 1'b0;
    @(negedge clk);

    // Back-to-back single-cycle ops, hand-computed results; flags {V,N,C,Z}.
    issue("add_7f_01", ALU_ADD, 8'h7F, 8'h01, K_WR, 8'h80, 8'h00, 4'b1100);
    issue("add_ff_01", ALU_ADD, 8'hFF, 8'h01, K_WR, 8'h00, 8'h00, 4'b0011);
    issue("sub_09_09", ALU_SUB, 8'h09, 8'h09, K_WR, 8'h00, 8'h00, 4'b0001);
    issue("and_f0_3c", ALU_AND, 8'hF0, 8'h3C, K_WR, 8'h30, 8'h00, 4'b0000);
    issue("cmp_05_09", ALU_CMP, 8'h05, 8'h09, K_CMP, 8'h00, 8'h00, 4'b0110);
    issue("or_a0_05",  ALU_OR,  8'hA0, 8'h05, K_WR, 8'hA5, 8'h00, 4'b0100);
    issue("xor_5a_5a", ALU_XOR, 8'h5A, 8'h5A, K_WR, 8'h00, 8'h00, 4'b0001);
    issue("sub_80_01", ALU_SUB, 8'h80, 8'h01, K_WR, 8'h7F, 8'h00, 4'b1000);
    idle(1);
    issue("ill_00", 8'h00, 8'h12, 8'h34, K_ILL, 8'h00, 8'h00, 4'b0000);
    issue("ill_03", 8'h03, 8'h12, 8'h34, K_ILL, 8'h00, 8'h00, 4'b0000);
    idle(2);

`ifdef ALU_MULDIV_EN
    issue("mul_ff_ff", ALU_MUL, 8'hFF, 8'hFF, K_MD, 8'h01, 8'hFE, 4'b0010);
    idle(2);
    // Request during the run must be ignored (no extra write afterwards).
    alu_en = 1'b1; alu_opr = ALU_ADD; a_in = 8'h11; b_in = 8'h22;
    @(negedge clk);
    idle(9);
    issue("div_200_7", ALU_DIV, 8'd200, 8'd7, K_MD, 8'd28, 8'd4, 4'b0000);
    idle(10);
    issue("div_10_0", ALU_DIV, 8'd10, 8'd0, K_WRH, 8'hFF, 8'd10, 4'b1110);
    issue("add_after_div", ALU_ADD, 8'h01, 8'h02, K_WR, 8'h03, 8'd10, 4'b0000);
    idle(2);
    issue("mul_rst", ALU_MUL, 8'h12, 8'h34, K_MDR, 8'h00, 8'h00, 4'b0000);
    alu_en = 1'b0;
    repeat (4) @(posedge clk);
`else
    issue("mul_disabled", ALU_MUL, 8'h03, 8'h05, K_ILL, 8'h00, 8'h00, 4'b0000);
    issue("div_disabled", ALU_DIV, 8'h09, 8'h03, K_ILL, 8'h00, 8'h00, 4'b0000);
    idle(2);
    issue("add_pre_rst", ALU_ADD, 8'h12, 8'h34, K_WR, 8'h46, 8'h00, 4'b0000);
    alu_en = 1'b0;
    repeat (2) @(posedge clk);
`endif
    // Asynchronous reset between clock edges.
    #2 rst = 1'b1;
    m_res = '0; m_hi = '0; m_flg = '0;
    push("reset_async", cyc, 1'b0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    #1 rst = 1'b0;
    idle(12);
    issue("add_post_rst", ALU_ADD, 8'h03, 8'h04, K_WR, 8'h07, 8'h00, 4'b0000);
    idle(2);

    for (int i = 0; i < 200 && sbq.size() > 0; i++) @(negedge clk);
    if (sbq.size() > 0) begin
      checks++; errors++;
      $display("FAIL drain_timeout: %0d expectations outstanding, required 0", sbq.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
